conv_stream_master: RTL and testbench
=====================================

Name: conv_stream_master

Overview:
- Host-side driver for the team's convolution engine, on the opposite end of its streaming interface.
- Host loads an input matrix and a kernel into local buffers, then pulses start.
- Block serialises both row-major onto the engine's 8-bit input streams, then collects the 16-bit result stream into a result buffer for random-access readback.
- Targets the valid-qualified revision of the convolution engine. Dimensions use the engine's "minus one" encoding (field value 2 means 3 rows).

Parameters:
TIMEOUT_CYCLES, 4096, max idle cycles between results in COLLECT before abort.
DATA_W, 8, matrix/kernel element width (fixed 8 in this revision).
ACC_W, 16, result element width (fixed 16 in this revision).

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
wr_en  input  1  buffer write strobe; honoured only in IDLE
wr_sel  input  1  0 = matrix buffer, 1 = kernel buffer
wr_row  input  4  write row
wr_col  input  4  write column
wr_data  input  8  write data
in_rows_m1  input  4  input rows minus one; sampled at start
in_cols_m1  input  4  input cols minus one; sampled at start
ker_rows_m1  input  4  kernel rows minus one; sampled at start
ker_cols_m1  input  4  kernel cols minus one; sampled at start
start  input  1  begin transfer; honoured only in IDLE
in_matrix  output  8  matrix stream data to engine
in_valid  output  1  in_matrix qualifier
kernel  output  8  kernel stream data to engine
ker_valid  output  1  kernel qualifier
out_matrix  input  16  result stream data from engine
out_valid  input  1  out_matrix qualifier
rd_row  input  4  result readback row
rd_col  input  4  result readback column
rd_data  output  16  result buffer [rd_row][rd_col], combinational
busy  output  1  high when state != IDLE
done  output  1  one-cycle pulse, all results captured
err  output  1  one-cycle pulse, bad dims or timeout

Behaviour:
- Reset (async) clears all registered outputs (in_matrix, kernel, in_valid, ker_valid, done, err = 0) and sets state IDLE. Buffers are not cleared.
- Derived counts: Nin = (in_rows_m1+1)(in_cols_m1+1); Nk = (ker_rows_m1+1)(ker_cols_m1+1).
- Output size: Orow = in_rows_m1-ker_rows_m1+1; Ocol = in_cols_m1-ker_cols_m1+1; Nout = Orow*Ocol.
- States: IDLE, SEND_MAT, SEND_KER, COLLECT, DONE.
- IDLE, start at edge T:
  - Dims are latched.
  - If ker_rows_m1 > in_rows_m1 or ker_cols_m1 > in_cols_m1: err=1 during cycle T+1, stay IDLE.
  - Otherwise go to SEND_MAT.
- SEND_MAT:
  - Registered outputs. Element n (row-major) is driven with in_valid=1 during cycle T+1+n, n=0..Nin-1.
  - Row/col counters wrap col at in_cols_m1.
- SEND_KER:
  - Follows with no gap. ker_valid=1 and kernel element k are driven during cycle T+1+Nin+k.
  - in_valid is 0 throughout. in_valid and ker_valid are never high together.
- COLLECT:
  - Entered after the last kernel element; both valids drop to 0.
  - Each out_valid edge writes out_matrix to result[r][c] at raster index; c wraps at Ocol-1, then r increments.
  - After the Nout-th capture, go to DONE.
  - An idle counter resets on each out_valid. At TIMEOUT_CYCLES consecutive cycles without out_valid: err pulse, return to IDLE, no done.
- DONE: done=1 for exactly one cycle, then IDLE.
- out_valid outside COLLECT is ignored; the result buffer is unchanged.
- wr_en and start while busy are ignored. A write in the same cycle as start is accepted (IDLE), so its data is streamed.
- rd_data is valid any time. Contents are undefined for indices not written in the last run.
- Arithmetic: counters are 4-bit per dimension plus 9-bit element/result counters, so 16x16 (256 elements) does not overflow.

Test Plan:
- Load 3x3 matrix 1..9 and 2x2 kernel {1,0,0,1}, dims 2,2,1,1, start at T -> in_valid high exactly T+1..T+9 carrying 1..9; ker_valid high T+10..T+13 carrying 1,0,0,1; no overlap.
- Same run; bench returns 6,8,12,14 with 0-3 idle cycles between -> rd (0,0)=6, (0,1)=8, (1,0)=12, (1,1)=14; done single pulse the cycle after the 4th capture; busy low next cycle.
- TIMEOUT_CYCLES=16; bench returns only 2 results -> err pulse 16 cycles after the 2nd, no done, state IDLE; next start works normally.
- ker_rows_m1=3 with in_rows_m1=2 -> err pulse at T+1; in_valid/ker_valid never asserted; busy stays 0.
- Assert rst mid SEND_MAT (element 4) -> in_valid, busy go 0 without waiting for a clock edge; a fresh start then streams from element 0.
- 16x16 matrix with 1x1 kernel, start pulses and wr_en during run -> 256 results captured, rd (15,15) = last value; extra start/wr_en ignored, buffers unchanged.

Source files
------------

// File: rtl/conv_stream_master_if.sv
// Streaming link between the host-side stream master and the convolution engine.
// The master drives the two operand streams and receives the result stream.
interface conv_stream_master_if #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 16
);
    logic [DATA_W-1:0] in_matrix;
    logic              in_valid;
    logic [DATA_W-1:0] kernel;
    logic              ker_valid;
    logic [ACC_W-1:0]  out_matrix;
    logic              out_valid;

    modport master (
        output in_matrix, in_valid, kernel, ker_valid,
        input  out_matrix, out_valid
    );

    modport slave (
        input  in_matrix, in_valid, kernel, ker_valid,
        output out_matrix, out_valid
    );
endinterface

// File: rtl/conv_stream_master.sv
// Host-side driver for the convolution engine: streams a buffered matrix and kernel
// row-major, then captures the result stream into a randomly readable buffer.
module conv_stream_master #(
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int DATA_W         = 8,
    parameter int ACC_W          = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic              wr_sel,
    input  logic [3:0]        wr_row,
    input  logic [3:0]        wr_col,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [3:0]        in_rows_m1,
    input  logic [3:0]        in_cols_m1,
    input  logic [3:0]        ker_rows_m1,
    input  logic [3:0]        ker_cols_m1,
    input  logic              start,
    conv_stream_master_if.master strm,
    input  logic [3:0]        rd_row,
    input  logic [3:0]        rd_col,
    output logic [ACC_W-1:0]  rd_data,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND_MAT,
        S_SEND_KER,
        S_COLLECT,
        S_DONE
    } state_e;

    typedef struct packed {
        logic [3:0] in_rows;
        logic [3:0] in_cols;
        logic [3:0] ker_rows;
        logic [3:0] ker_cols;
    } dims_t;

    typedef logic [IDLE_W-1:0] idle_t;

    state_e state_q, state_d;
    dims_t  dims_q, dims_d, start_dims;

    logic [DATA_W-1:0] in_matrix_q, in_matrix_d;
    logic [DATA_W-1:0] kernel_q, kernel_d;
    logic              in_valid_q, in_valid_d;
    logic              ker_valid_q, ker_valid_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [3:0]        row_q, row_d;
    logic [3:0]        col_q, col_d;
    logic [8:0]        res_cnt_q, res_cnt_d;
    idle_t             idle_q, idle_d;
    logic              res_we;

    logic [DATA_W-1:0] mat_mem [16][16];
    logic [DATA_W-1:0] ker_mem [16][16];
    logic [ACC_W-1:0]  res_mem [16][16];

    logic              dims_bad;
    logic              mat_end, ker_end, res_last, timeout_hit;
    logic [3:0]        orow_m1, ocol_m1;
    logic [8:0]        nout;
    logic [DATA_W-1:0] first_mat;

    assign start_dims = '{in_rows: in_rows_m1, in_cols: in_cols_m1,
                          ker_rows: ker_rows_m1, ker_cols: ker_cols_m1};
    assign dims_bad   = (ker_rows_m1 > in_rows_m1) || (ker_cols_m1 > in_cols_m1);

    assign mat_end = (row_q == dims_q.in_rows)  && (col_q == dims_q.in_cols);
    assign ker_end = (row_q == dims_q.ker_rows) && (col_q == dims_q.ker_cols);

    assign orow_m1  = dims_q.in_rows - dims_q.ker_rows;
    assign ocol_m1  = dims_q.in_cols - dims_q.ker_cols;
    assign nout     = (9'(orow_m1) + 9'd1) * (9'(ocol_m1) + 9'd1);
    assign res_last = (res_cnt_q + 9'd1) == nout;

    assign timeout_hit = !strm.out_valid && (idle_q == IDLE_W'(TIMEOUT_CYCLES - 1));

    // A write landing on element (0,0) in the start cycle is not yet in the buffer.
    assign first_mat = (wr_en && !wr_sel && wr_row == 4'd0 && wr_col == 4'd0)
                     ? wr_data : mat_mem[0][0];

    // NOTE: state and datapath registers use non-blocking assignments so every flop
    // samples the pre-edge value of every other flop, independent of process order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // NOTE: every combinational output gets a default before the case, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:     if (start && !dims_bad) state_d = S_SEND_MAT;
            S_SEND_MAT: if (mat_end)            state_d = S_SEND_KER;
            S_SEND_KER: if (ker_end)            state_d = S_COLLECT;
            S_COLLECT: begin
                if (strm.out_valid && res_last) state_d = S_DONE;
                else if (timeout_hit)           state_d = S_IDLE;
            end
            S_DONE:                             state_d = S_IDLE;
            default:                            state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_matrix_d = in_matrix_q;
        in_valid_d  = in_valid_q;
        kernel_d    = kernel_q;
        ker_valid_d = ker_valid_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        dims_d      = dims_q;
        row_d       = row_q;
        col_d       = col_q;
        res_cnt_d   = res_cnt_q;
        idle_d      = idle_q;
        res_we      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    dims_d = start_dims;
                    if (dims_bad) begin
                        err_d = 1'b1;
                    end else begin
                        in_valid_d  = 1'b1;
                        in_matrix_d = first_mat;
                        row_d       = 4'd0;
                        col_d       = 4'd0;
                    end
                end
            end

            S_SEND_MAT: begin
                if (mat_end) begin
                    in_valid_d  = 1'b0;
                    in_matrix_d = '0;
                    ker_valid_d = 1'b1;
                    kernel_d    = ker_mem[0][0];
                    row_d       = 4'd0;
                    col_d       = 4'd0;
                end else begin
                    if (col_q == dims_q.in_cols) begin
                        row_d = row_q + 4'd1;
                        col_d = 4'd0;
                    end else begin
                        col_d = col_q + 4'd1;
                    end
                    in_matrix_d = mat_mem[row_d][col_d];
                end
            end

            S_SEND_KER: begin
                if (ker_end) begin
                    ker_valid_d = 1'b0;
                    kernel_d    = '0;
                    row_d       = 4'd0;
                    col_d       = 4'd0;
                    res_cnt_d   = '0;
                    idle_d      = '0;
                end else begin
                    if (col_q == dims_q.ker_cols) begin
                        row_d = row_q + 4'd1;
                        col_d = 4'd0;
                    end else begin
                        col_d = col_q + 4'd1;
                    end
                    kernel_d = ker_mem[row_d][col_d];
                end
            end

            S_COLLECT: begin
                if (strm.out_valid) begin
                    res_we    = 1'b1;
                    res_cnt_d = res_cnt_q + 9'd1;
                    idle_d    = '0;
                    if (col_q == ocol_m1) begin
                        row_d = row_q + 4'd1;
                        col_d = 4'd0;
                    end else begin
                        col_d = col_q + 4'd1;
                    end
                    if (res_last) done_d = 1'b1;
                end else if (timeout_hit) begin
                    err_d = 1'b1;
                end else begin
                    idle_d = idle_q + idle_t'(1);
                end
            end

            S_DONE: ;

            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_matrix_q <= '0;
            in_valid_q  <= 1'b0;
            kernel_q    <= '0;
            ker_valid_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            dims_q      <= '0;
            row_q       <= '0;
            col_q       <= '0;
            res_cnt_q   <= '0;
            idle_q      <= '0;
        end else begin
            in_matrix_q <= in_matrix_d;
            in_valid_q  <= in_valid_d;
            kernel_q    <= kernel_d;
            ker_valid_q <= ker_valid_d;
            done_q      <= done_d;
            err_q       <= err_d;
            dims_q      <= dims_d;
            row_q       <= row_d;
            col_q       <= col_d;
            res_cnt_q   <= res_cnt_d;
            idle_q      <= idle_d;
        end
    end

    // NOTE: the buffers hold data only and are left out of reset; resetting them
    // would stop them mapping onto RAM and nothing depends on their initial contents.
    always_ff @(posedge clk) begin
        if (wr_en && state_q == S_IDLE) begin
            if (wr_sel) ker_mem[wr_row][wr_col] <= wr_data;
            else        mat_mem[wr_row][wr_col] <= wr_data;
        end
        if (res_we) res_mem[row_q][col_q] <= strm.out_matrix;
    end

    assign strm.in_matrix = in_matrix_q;
    assign strm.in_valid  = in_valid_q;
    assign strm.kernel    = kernel_q;
    assign strm.ker_valid = ker_valid_q;

    assign rd_data = res_mem[rd_row][rd_col];
    assign busy    = (state_q != S_IDLE);
    assign done    = done_q;
    assign err     = err_q;

endmodule

// File: tb/tb_conv_stream_master.sv
// Directed bench for conv_stream_master: streaming order, result capture, timeout,
// bad dimensions, asynchronous reset and a full 16x16 run.
module tb_conv_stream_master;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en, wr_sel;
    logic [3:0]  wr_row, wr_col;
    logic [7:0]  wr_data;
    logic [3:0]  in_rows_m1, in_cols_m1, ker_rows_m1, ker_cols_m1;
    logic        start;
    logic [3:0]  rd_row, rd_col;
    logic [15:0] rd_data;
    logic        busy, done, err;

    int checks = 0;
    int errors = 0;
    int done_pulses = 0;
    int err_pulses = 0;
    int overlap = 0;

    always #5 clk = ~clk;

    conv_stream_master_if sif ();

    conv_stream_master #(.TIMEOUT_CYCLES(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_sel      (wr_sel),
        .wr_row      (wr_row),
        .wr_col      (wr_col),
        .wr_data     (wr_data),
        .in_rows_m1  (in_rows_m1),
        .in_cols_m1  (in_cols_m1),
        .ker_rows_m1 (ker_rows_m1),
        .ker_cols_m1 (ker_cols_m1),
        .start       (start),
        .strm        (sif),
        .rd_row      (rd_row),
        .rd_col      (rd_col),
        .rd_data     (rd_data),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    always @(negedge clk) begin
        if (done) done_pulses++;
        if (err) err_pulses++;
        if (sif.in_valid && sif.ker_valid) overlap++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_elem(input logic sel, input int r, input int c, input logic [7:0] d);
        wr_en = 1'b1; wr_sel = sel; wr_row = 4'(r); wr_col = 4'(c); wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic set_dims(input int ir, input int ic, input int kr, input int kc);
        in_rows_m1 = 4'(ir); in_cols_m1 = 4'(ic); ker_rows_m1 = 4'(kr); ker_cols_m1 = 4'(kc);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        checks++; if (sif.in_valid !== 1'b0) begin errors++; $display("FAIL reset in_valid: got %b expected 0", sif.in_valid); end
        checks++; if (sif.ker_valid !== 1'b0) begin errors++; $display("FAIL reset ker_valid: got %b expected 0", sif.ker_valid); end
        checks++; if (sif.in_matrix !== 8'h00) begin errors++; $display("FAIL reset in_matrix: got %h expected 00", sif.in_matrix); end
        checks++; if (sif.kernel !== 8'h00) begin errors++; $display("FAIL reset kernel: got %h expected 00", sif.kernel); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset done: got %b expected 0", done); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset err: got %b expected 0", err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b expected 0", busy); end
        rst = 1'b0;
        tick();
    endtask

    task automatic load_3x3();
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                write_elem(1'b0, r, c, 8'(r * 3 + c + 1));
        write_elem(1'b1, 0, 0, 8'd1);
        write_elem(1'b1, 0, 1, 8'd0);
        write_elem(1'b1, 1, 0, 8'd0);
        write_elem(1'b1, 1, 1, 8'd1);
    endtask

    // 3x3 matrix 1..9 then 2x2 kernel {1,0,0,1}; ends in COLLECT (cycle T+14).
    task automatic test_stream();
        pulse_start();
        for (int n = 0; n < 14; n++) begin
            logic exp_iv, exp_kv;
            logic [7:0] exp_k;
            exp_iv = (n < 9);
            exp_kv = (n >= 9) && (n < 13);
            exp_k  = (n == 9 || n == 12) ? 8'd1 : 8'd0;
            checks++; if (sif.in_valid !== exp_iv) begin errors++; $display("FAIL stream in_valid n=%0d: got %b expected %b", n, sif.in_valid, exp_iv); end
            checks++; if (sif.ker_valid !== exp_kv) begin errors++; $display("FAIL stream ker_valid n=%0d: got %b expected %b", n, sif.ker_valid, exp_kv); end
            if (exp_iv) begin
                checks++; if (sif.in_matrix !== 8'(n + 1)) begin errors++; $display("FAIL stream in_matrix n=%0d: got %0d expected %0d", n, sif.in_matrix, n + 1); end
            end
            if (exp_kv) begin
                checks++; if (sif.kernel !== exp_k) begin errors++; $display("FAIL stream kernel n=%0d: got %0d expected %0d", n, sif.kernel, exp_k); end
            end
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL stream busy n=%0d: got %b expected 1", n, busy); end
            if (n < 13) tick();
        end
    endtask

    // Returns 6,8,12,14 (+base) with 0..3 idle cycles between them.
    task automatic test_collect(input int base);
        int vals [4] = '{6, 8, 12, 14};
        int d0;
        d0 = done_pulses;
        for (int i = 0; i < 4; i++) begin
            for (int g = 0; g < i; g++) tick();
            sif.out_valid = 1'b1;
            sif.out_matrix = 16'(vals[i] + base);
            tick();
            sif.out_valid = 1'b0;
            checks++; if (done !== (i == 3)) begin errors++; $display("FAIL collect done after capture %0d: got %b expected %b", i, done, (i == 3)); end
        end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL collect busy in done cycle: got %b expected 1", busy); end
        tick();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL collect done second cycle: got %b expected 0", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL collect busy after done: got %b expected 0", busy); end
        checks++; if (done_pulses - d0 !== 1) begin errors++; $display("FAIL collect done pulse count: got %0d expected 1", done_pulses - d0); end
        for (int i = 0; i < 4; i++) begin
            rd_row = 4'(i / 2); rd_col = 4'(i % 2);
            #1;
            checks++; if (rd_data !== 16'(vals[i] + base)) begin errors++; $display("FAIL collect rd(%0d,%0d): got %0d expected %0d", i / 2, i % 2, rd_data, vals[i] + base); end
        end
    endtask

    task automatic test_timeout();
        int d0;
        d0 = done_pulses;
        pulse_start();
        for (int n = 0; n < 13; n++) tick();
        for (int i = 0; i < 2; i++) begin
            sif.out_valid = 1'b1;
            sif.out_matrix = 16'(50 + i);
            tick();
        end
        sif.out_valid = 1'b0;
        for (int k = 1; k <= 17; k++) begin
            tick();
            checks++; if (err !== (k == 16)) begin errors++; $display("FAIL timeout err k=%0d: got %b expected %b", k, err, (k == 16)); end
            checks++; if (busy !== (k < 16)) begin errors++; $display("FAIL timeout busy k=%0d: got %b expected %b", k, busy, (k < 16)); end
        end
        checks++; if (done_pulses !== d0) begin errors++; $display("FAIL timeout done pulses: got %0d expected %0d", done_pulses, d0); end
        test_stream();
        test_collect(100);
    endtask

    task automatic test_bad_dims();
        int e0;
        e0 = err_pulses;
        set_dims(2, 2, 3, 1);
        pulse_start();
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL bad_dims err at T+1: got %b expected 1", err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bad_dims busy at T+1: got %b expected 0", busy); end
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++; if (err !== 1'b0) begin errors++; $display("FAIL bad_dims err k=%0d: got %b expected 0", k, err); end
            checks++; if ({busy, sif.in_valid, sif.ker_valid} !== 3'b000) begin errors++; $display("FAIL bad_dims busy/valids k=%0d: got %b expected 000", k, {busy, sif.in_valid, sif.ker_valid}); end
        end
        checks++; if (err_pulses - e0 !== 1) begin errors++; $display("FAIL bad_dims err pulse count: got %0d expected 1", err_pulses - e0); end
    endtask

    task automatic test_reset_mid();
        set_dims(2, 2, 1, 1);
        pulse_start();
        for (int n = 0; n < 4; n++) tick();
        checks++; if (sif.in_matrix !== 8'd5) begin errors++; $display("FAIL reset_mid element 4: got %0d expected 5", sif.in_matrix); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (sif.in_valid !== 1'b0) begin errors++; $display("FAIL reset_mid in_valid: got %b expected 0", sif.in_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_mid busy: got %b expected 0", busy); end
        #1;
        rst = 1'b0;
        test_stream();
        test_collect(0);
    endtask

    task automatic test_big();
        int d0;
        set_dims(15, 15, 0, 0);
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++)
                write_elem(1'b0, r, c, 8'(r * 16 + c));
        write_elem(1'b1, 0, 0, 8'h07);
        pulse_start();
        for (int n = 0; n < 258; n++) begin
            if (n < 256) begin
                checks++; if ({sif.in_valid, sif.ker_valid, sif.in_matrix} !== {2'b10, 8'(n)}) begin errors++; $display("FAIL big matrix n=%0d: got iv=%b kv=%b d=%0d expected iv=1 kv=0 d=%0d", n, sif.in_valid, sif.ker_valid, sif.in_matrix, n); end
            end else if (n == 256) begin
                checks++; if ({sif.in_valid, sif.ker_valid, sif.kernel} !== {2'b01, 8'h07}) begin errors++; $display("FAIL big kernel: got iv=%b kv=%b d=%h expected iv=0 kv=1 d=07", sif.in_valid, sif.ker_valid, sif.kernel); end
            end else begin
                checks++; if ({sif.in_valid, sif.ker_valid} !== 2'b00) begin errors++; $display("FAIL big valids in collect: got %b expected 00", {sif.in_valid, sif.ker_valid}); end
            end
            start = (n == 3);
            wr_en = (n == 10) || (n == 20) || (n == 30);
            wr_sel = (n == 20);
            wr_row = (n == 10) ? 4'd15 : 4'd0;
            wr_col = (n == 10) ? 4'd15 : 4'd0;
            wr_data = (n == 10) ? 8'hEE : (n == 20) ? 8'h55 : 8'hCC;
            if (n < 257) tick();
        end
        start = 1'b0; wr_en = 1'b0;
        d0 = done_pulses;
        for (int i = 0; i < 256; i++) begin
            sif.out_valid = 1'b1;
            sif.out_matrix = 16'(16'h1000 + i * 3);
            start = (i == 100);
            wr_en = (i == 100); wr_sel = 1'b0; wr_row = 4'd0; wr_col = 4'd0; wr_data = 8'h99;
            tick();
        end
        sif.out_valid = 1'b0; start = 1'b0; wr_en = 1'b0;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL big done after 256: got %b expected 1", done); end
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL big busy after done: got %b expected 0", busy); end
        checks++; if (done_pulses - d0 !== 1) begin errors++; $display("FAIL big done pulse count: got %0d expected 1", done_pulses - d0); end
        rd_row = 4'd15; rd_col = 4'd15; #1;
        checks++; if (rd_data !== 16'h12FD) begin errors++; $display("FAIL big rd(15,15): got %h expected 12fd", rd_data); end
        rd_row = 4'd0; rd_col = 4'd0; #1;
        checks++; if (rd_data !== 16'h1000) begin errors++; $display("FAIL big rd(0,0): got %h expected 1000", rd_data); end
        rd_row = 4'd7; rd_col = 4'd9; #1;
        checks++; if (rd_data !== 16'h116B) begin errors++; $display("FAIL big rd(7,9): got %h expected 116b", rd_data); end
        // Stray result outside COLLECT must not touch the buffer.
        sif.out_valid = 1'b1; sif.out_matrix = 16'hDEAD;
        tick();
        sif.out_valid = 1'b0;
        rd_row = 4'd15; rd_col = 4'd15; #1;
        checks++; if (rd_data !== 16'h12FD) begin errors++; $display("FAIL big stray out_valid rd(15,15): got %h expected 12fd", rd_data); end
        rd_row = 4'd0; rd_col = 4'd0; #1;
        checks++; if (rd_data !== 16'h1000) begin errors++; $display("FAIL big stray out_valid rd(0,0): got %h expected 1000", rd_data); end
        // 1x1 run shows the writes attempted while busy never landed.
        set_dims(0, 0, 0, 0);
        pulse_start();
        checks++; if ({sif.in_valid, sif.in_matrix} !== {1'b1, 8'h00}) begin errors++; $display("FAIL big buffer matrix(0,0): got iv=%b d=%h expected iv=1 d=00", sif.in_valid, sif.in_matrix); end
        tick();
        checks++; if ({sif.ker_valid, sif.kernel} !== {1'b1, 8'h07}) begin errors++; $display("FAIL big buffer kernel(0,0): got kv=%b d=%h expected kv=1 d=07", sif.ker_valid, sif.kernel); end
        tick();
        sif.out_valid = 1'b1; sif.out_matrix = 16'h4242;
        tick();
        sif.out_valid = 1'b0;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL big 1x1 done: got %b expected 1", done); end
        tick();
        rd_row = 4'd0; rd_col = 4'd0; #1;
        checks++; if (rd_data !== 16'h4242) begin errors++; $display("FAIL big 1x1 rd(0,0): got %h expected 4242", rd_data); end
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_sel = 1'b0; wr_row = '0; wr_col = '0; wr_data = '0;
        start = 1'b0; rd_row = '0; rd_col = '0;
        sif.out_valid = 1'b0; sif.out_matrix = '0;
        set_dims(0, 0, 0, 0);
        test_reset();
        load_3x3();
        set_dims(2, 2, 1, 1);
        test_stream();
        test_collect(0);
        test_timeout();
        test_bad_dims();
        test_reset_mid();
        test_big();
        checks++; if (overlap !== 0) begin errors++; $display("FAIL overlap in_valid&ker_valid: got %0d cycles expected 0", overlap); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
